// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data handshake bundle carrying one packed multi-channel pipeline word.
interface pipe_stage_reg_if #(
  parameter int unsigned DW = 24
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush and
// an optional 2-entry skid buffer that makes the upstream ready a flop output.
module pipe_stage_reg #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned SKID     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  pipe_stage_reg_if.slave        up,
  pipe_stage_reg_if.master       dn,
  output logic [1:0]             occupancy
);
  localparam int unsigned DW = WIDTH * CHANNELS;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [DW-1:0] main_q, skid_q;
  logic          ready_q, ready_d;
  logic          accept, take;
  logic          load_in, load_skid, pop_skid;

  // Without the skid entry, ready must see downstream ready in the same cycle.
  assign up.ready  = (SKID != 0) ? ready_q : (dn.ready | (state == EMPTY));
  assign dn.valid  = (state != EMPTY);
  assign dn.data   = main_q;
  assign occupancy = 2'(state);

  assign accept = up.valid & up.ready;
  assign take   = dn.valid & dn.ready;

  always_comb begin
    state_d   = state;
    load_in   = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            load_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && !take && (SKID != 0)) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (accept) begin
            load_in = 1'b1;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (take) begin
            state_d  = ONE;
            pop_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_d;
      ready_q <= ready_d;
      if (load_in)       main_q <= up.data;
      else if (pop_skid) main_q <= skid_q;
      if (load_skid)     skid_q <= up.data;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: one skid-buffered and one single-register instance side by side.
module tb_pipe_stage_reg;
  localparam int unsigned W  = 8;
  localparam int unsigned C  = 3;
  localparam int unsigned DW = W * C;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush1, flush0;
  logic [1:0]    occ1, occ0;
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] t2 [3];
  int            n_checks = 0;
  int            n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DW(DW)) up1 ();
  pipe_stage_reg_if #(.DW(DW)) dn1 ();
  pipe_stage_reg_if #(.DW(DW)) up0 ();
  pipe_stage_reg_if #(.DW(DW)) dn0 ();

  pipe_stage_reg #(.WIDTH(W), .CHANNELS(C), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush1),
    .up(up1.slave), .dn(dn1.master), .occupancy(occ1)
  );

  pipe_stage_reg #(.WIDTH(W), .CHANNELS(C), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0),
    .up(up0.slave), .dn(dn0.master), .occupancy(occ0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st1(input string tag, input logic v, input logic [1:0] o, input logic r);
    chk({tag, " s1 valid"}, 32'(dn1.valid), 32'(v));
    chk({tag, " s1 occ"},   32'(occ1),      32'(o));
    chk({tag, " s1 ready"}, 32'(up1.ready), 32'(r));
  endtask

  task automatic st0(input string tag, input logic v, input logic [1:0] o, input logic r);
    chk({tag, " s0 valid"}, 32'(dn0.valid), 32'(v));
    chk({tag, " s0 occ"},   32'(occ0),      32'(o));
    chk({tag, " s0 ready"}, 32'(up0.ready), 32'(r));
  endtask

  // Output monitors: every transfer downstream must match the next expected word.
  always @(negedge clk) begin
    if (dn1.valid && dn1.ready) begin
      if (q1.size() == 0) begin
        n_checks++;
        $display("FAIL sb1: got unexpected word 0x%0h expected none", dn1.data);
      end else begin
        chk("sb1 word", 32'(dn1.data), 32'(q1.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (dn0.valid && dn0.ready) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL sb0: got unexpected word 0x%0h expected none", dn0.data);
      end else begin
        chk("sb0 word", 32'(dn0.data), 32'(q0.pop_front()));
      end
    end
  end

  initial begin
    t2[0] = 24'h010203;
    t2[1] = 24'h040506;
    t2[2] = 24'h070809;
    reset = 1'b0; flush1 = 1'b0; flush0 = 1'b0;
    up1.valid = 1'b1; up1.data = 24'h123456; dn1.ready = 1'b1;
    up0.valid = 1'b1; up0.data = 24'h123456; dn0.ready = 1'b1;

    // reset with a word offered
    repeat (2) step();
    st1("t1 in", 1'b0, 2'd0, 1'b1);
    chk("t1 s1 data", 32'(dn1.data), 32'h0);
    reset = 1'b1; up1.valid = 1'b0; up0.valid = 1'b0;
    step();
    st1("t1 out", 1'b0, 2'd0, 1'b1);
    st0("t1 out", 1'b0, 2'd0, 1'b1);
    chk("t1 s0 data", 32'(dn0.data), 32'h0);

    // streaming pass-through on both variants
    for (int i = 0; i < 3; i++) begin
      up1.valid = 1'b1; up1.data = t2[i]; q1.push_back(t2[i]);
      up0.valid = 1'b1; up0.data = t2[i]; q0.push_back(t2[i]);
      step();
      st1("t2", 1'b1, 2'd1, 1'b1);
      st0("t2", 1'b1, 2'd1, 1'b1);
      chk("t2 s1 data", 32'(dn1.data), 32'(t2[i]));
    end
    up1.valid = 1'b0; up0.valid = 1'b0;
    step();
    st1("t2 end", 1'b0, 2'd0, 1'b1);
    st0("t2 end", 1'b0, 2'd0, 1'b1);

    // back-pressure fills the skid entry
    q1.push_back(24'hAA0001); q1.push_back(24'hAA0002); q1.push_back(24'hAA0003);
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 24'hAA0001;
    step();
    st1("t3 a", 1'b1, 2'd1, 1'b1);
    up1.data = 24'hAA0002;
    step();
    st1("t3 b", 1'b1, 2'd2, 1'b0);
    up1.data = 24'hAA0003;
    step();
    st1("t3 hold", 1'b1, 2'd2, 1'b0);
    chk("t3 hold data", 32'(dn1.data), 32'hAA0001);
    dn1.ready = 1'b1;
    step();
    st1("t3 drain", 1'b1, 2'd1, 1'b1);
    chk("t3 drain data", 32'(dn1.data), 32'hAA0002);
    step();
    chk("t3 c data", 32'(dn1.data), 32'hAA0003);
    up1.valid = 1'b0;
    step();
    st1("t3 end", 1'b0, 2'd0, 1'b1);

    // flush while full, then flush while half full with a word accepted-able
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 24'hCC0001;
    step();
    up1.data = 24'hCC0002;
    step();
    st1("t4 full", 1'b1, 2'd2, 1'b0);
    flush1 = 1'b1; up1.data = 24'hBB0000;
    step();
    flush1 = 1'b0; up1.valid = 1'b0;
    st1("t4 flush", 1'b0, 2'd0, 1'b1);
    chk("t4 stale data", 32'(dn1.data), 32'hCC0001);
    up1.valid = 1'b1; up1.data = 24'hDD0001;
    step();
    flush1 = 1'b1; up1.data = 24'hDD0002;
    step();
    flush1 = 1'b0; up1.valid = 1'b0;
    st1("t4 flush1", 1'b0, 2'd0, 1'b1);
    dn1.ready = 1'b1;
    repeat (3) step();
    st1("t4 idle", 1'b0, 2'd0, 1'b1);

    // reset in the middle of a full skid
    dn1.ready = 1'b0;
    up1.valid = 1'b1; up1.data = 24'hEE0001;
    step();
    up1.data = 24'hEE0002;
    step();
    st1("t5 full", 1'b1, 2'd2, 1'b0);
    up1.valid = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1;
    st1("t5 rst", 1'b0, 2'd0, 1'b1);
    chk("t5 rst data", 32'(dn1.data), 32'h0);
    dn1.ready = 1'b1;
    up1.valid = 1'b1; up1.data = 24'h0C0C0C; q1.push_back(24'h0C0C0C);
    step();
    up1.valid = 1'b0;
    st1("t5 word", 1'b1, 2'd1, 1'b1);
    chk("t5 word data", 32'(dn1.data), 32'h0C0C0C);
    step();
    st1("t5 end", 1'b0, 2'd0, 1'b1);

    // single-register variant: combinational ready follows out_ready
    dn0.ready = 1'b0;
    up0.valid = 1'b1; up0.data = 24'h222222; q0.push_back(24'h222222);
    step();
    up0.valid = 1'b0;
    #1;
    st0("t6 stall", 1'b1, 2'd1, 1'b0);
    step();
    chk("t6 hold data", 32'(dn0.data), 32'h222222);
    dn0.ready = 1'b1;
    up0.valid = 1'b1; up0.data = 24'h111111; q0.push_back(24'h111111);
    #1;
    chk("t6 ready comb", 32'(up0.ready), 32'h1);
    step();
    up0.valid = 1'b0;
    st0("t6 replace", 1'b1, 2'd1, 1'b1);
    chk("t6 replace data", 32'(dn0.data), 32'h111111);
    step();
    st0("t6 end", 1'b0, 2'd0, 1'b1);

    step();
    chk("q1 drained", 32'(q1.size()), 32'h0);
    chk("q0 drained", 32'(q0.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
